// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Purpose  : Two-source serial transmit controller. A round-robin arbiter
//            chooses between two byte requesters. The module latches the
//            winning byte into an 11-bit frame (start, 8 data bits LSB-first,
//            parity, stop) and shifts the frame onto txd one bit per baud
//            tick.
// Ports    : clk, rst          - system clock, synchronous active-high reset
//            en                - one-cycle baud tick
//            req1/req2         - level requests; data1/data2 - offered bytes
//            gnt1/gnt2         - one-cycle grant pulses (byte latched)
//            txd               - serial line, idles high
//            busy              - grant through end of frame
//            done              - one-cycle pulse after the stop bit period
//            owner             - 0 = source 1, 1 = source 2 (current/last frame)
//            bit_idx           - index of the frame bit on txd (debug)
// Revision : 1.0 - initial release
// ============================================================================
module tx_arbiter #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req1,
    input  logic       req2,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       txd,
    output logic       busy,
    output logic       done,
    output logic       owner,
    output logic [3:0] bit_idx
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_SEND     = 2'd2;
    localparam logic [3:0] c_LAST_BIT = 4'd10;

    logic [1:0]  r_state;
    logic [10:0] r_frame;
    logic        r_txd;
    logic        r_busy;
    logic        r_gnt1;
    logic        r_gnt2;
    logic        r_done;
    logic        r_owner;
    logic [3:0]  r_bit_idx;

    logic [1:0]  w_state_nxt;
    logic [10:0] w_frame_nxt;
    logic        w_txd_nxt;
    logic        w_busy_nxt;
    logic        w_gnt1_nxt;
    logic        w_gnt2_nxt;
    logic        w_done_nxt;
    logic        w_owner_nxt;
    logic [3:0]  w_bit_idx_nxt;

    logic        w_any_req;
    logic        w_pick2;
    logic [7:0]  w_sel_data;
    logic [10:0] w_frame_new;
    logic [3:0]  w_bit_idx_inc;

    // Source 2 wins when it is the only requester, or on a tie when source 1
    // owned the previous frame (owner == 0).
    assign w_any_req     = req1 | req2;
    assign w_pick2       = req2 & (~req1 | ~r_owner);
    assign w_sel_data    = w_pick2 ? data2 : data1;
    assign w_frame_new   = {1'b1, (^w_sel_data) ^ PARITY_ODD, w_sel_data, 1'b0};
    assign w_bit_idx_inc = r_bit_idx + 4'd1;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_frame   <= 11'h7FF;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_gnt2    <= 1'b0;
            r_done    <= 1'b0;
            r_owner   <= 1'b1;
            r_bit_idx <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= w_busy_nxt;
            r_gnt1    <= w_gnt1_nxt;
            r_gnt2    <= w_gnt2_nxt;
            r_done    <= w_done_nxt;
            r_owner   <= w_owner_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_any_req) w_state_nxt = c_WAIT;
            c_WAIT: if (en)        w_state_nxt = c_SEND;
            c_SEND: if (en && (r_bit_idx == c_LAST_BIT)) w_state_nxt = c_IDLE;
            default:               w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computes the next value of every registered output.
    // Grant and done are pulses, so they default low each cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_frame_nxt   = r_frame;
        w_txd_nxt     = r_txd;
        w_busy_nxt    = r_busy;
        w_gnt1_nxt    = 1'b0;
        w_gnt2_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_owner_nxt   = r_owner;
        w_bit_idx_nxt = r_bit_idx;
        case (r_state)
            c_IDLE: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                if (w_any_req) begin
                    w_frame_nxt = w_frame_new;
                    w_owner_nxt = w_pick2;
                    w_gnt1_nxt  = ~w_pick2;
                    w_gnt2_nxt  = w_pick2;
                    w_busy_nxt  = 1'b1;
                end
            end
            c_WAIT: begin
                // A tick landing on the grant edge is seen while still in
                // IDLE, so the start bit always waits for a later tick.
                if (en) begin
                    w_bit_idx_nxt = 4'd0;
                    w_txd_nxt     = r_frame[0];
                end
            end
            c_SEND: begin
                if (en) begin
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_txd_nxt  = 1'b1;
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_idx_inc;
                        w_txd_nxt     = r_frame[w_bit_idx_inc];
                    end
                end
            end
            default: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign gnt1    = r_gnt1;
    assign gnt2    = r_gnt2;
    assign txd     = r_txd;
    assign busy    = r_busy;
    assign done    = r_done;
    assign owner   = r_owner;
    assign bit_idx = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Purpose  : Directed self-checking bench for tx_arbiter. An even-parity and
//            an odd-parity instance share all inputs. Inputs change on the
//            falling edge, and outputs are sampled there as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       req1 = 1'b0;
    logic       req2 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;

    logic       gnt1, gnt2, txd, busy, done, owner;
    logic [3:0] bit_idx;
    logic       odd_gnt1, odd_gnt2, odd_txd, odd_busy, odd_done, odd_owner;
    logic [3:0] odd_bit_idx;

    int n_total = 0;
    int n_bad   = 0;

    tx_arbiter #(.PARITY_ODD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req1(req1), .req2(req2),
        .data1(data1), .data2(data2), .gnt1(gnt1), .gnt2(gnt2), .txd(txd),
        .busy(busy), .done(done), .owner(owner), .bit_idx(bit_idx)
    );

    tx_arbiter #(.PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .en(en), .req1(req1), .req2(req2),
        .data1(data1), .data2(data2), .gnt1(odd_gnt1), .gnt2(odd_gnt2),
        .txd(odd_txd), .busy(odd_busy), .done(odd_done), .owner(odd_owner),
        .bit_idx(odd_bit_idx)
    );

    always #5 clk = ~clk;

    // Drive en for the coming rising edge, then return at the next falling
    // edge with the outputs of that rising edge visible.
    task automatic clk_step(input logic e);
        en = e;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
        clk_step(1'b0);
        clk_step(1'b0);
        rst = 1'b0;
    endtask

    // Run one frame from WAIT through the done edge with an en period of
    // 'per' clocks. Captures each bit as it appears. Also counts txd changes
    // between ticks, busy/done anomalies, grant pulses and divergence of the
    // odd instance's control outputs.
    task automatic run_frame(input int per, output logic [10:0] bits_e,
                             output logic [10:0] bits_o, output int bad_idx,
                             output int glitches, output int gnts);
        logic prev;
        prev = 1'b1; bad_idx = 0; glitches = 0; gnts = 0;
        bits_e = '0; bits_o = '0;
        for (int b = 0; b <= 11; b++) begin
            for (int k = 0; k < per; k++) begin
                clk_step(k == per - 1);
                if (k < per - 1) begin
                    if (txd !== prev)   glitches++;
                    if (busy !== 1'b1)  glitches++;
                    if (done !== 1'b0)  glitches++;
                end
                if ({odd_gnt1, odd_gnt2, odd_busy, odd_done, odd_owner, odd_bit_idx} !==
                    {gnt1, gnt2, busy, done, owner, bit_idx}) glitches++;
                if (gnt1 || gnt2) gnts++;
            end
            if (b <= 10) begin
                bits_e[b] = txd;
                bits_o[b] = odd_txd;
                if (bit_idx !== 4'(b)) bad_idx++;
                prev = txd;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (txd !== 1'b1)     begin n_bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
        n_total++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_total++; if ({gnt1, gnt2} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got=%b exp=00", {gnt1, gnt2}); end
        n_total++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_total++; if (bit_idx !== 4'd0) begin n_bad++; $display("FAIL reset_bit_idx got=%0d exp=0", bit_idx); end
        n_total++; if (owner !== 1'b1)   begin n_bad++; $display("FAIL reset_owner got=%b exp=1", owner); end
        // Reset asserted together with a request: no grant.
        rst = 1'b1; req1 = 1'b1;
        clk_step(1'b0);
        n_total++; if ({gnt1, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_vs_req got=%b exp=00", {gnt1, busy}); end
        rst = 1'b0; req1 = 1'b0;
        clk_step(1'b0);
        n_total++; if (gnt1 !== 1'b0)    begin n_bad++; $display("FAIL reset_vs_req_late got=%b exp=0", gnt1); end
    endtask

    task automatic test_single_send();
        logic [10:0] fe, fo; int bi, gl, gn;
        do_reset();
        data1 = 8'hA5; req1 = 1'b1;
        clk_step(1'b0);
        n_total++; if ({gnt1, gnt2} !== 2'b10) begin n_bad++; $display("FAIL single_gnt got=%b exp=10", {gnt1, gnt2}); end
        n_total++; if (owner !== 1'b0)   begin n_bad++; $display("FAIL single_owner got=%b exp=0", owner); end
        n_total++; if ({busy, txd} !== 2'b11) begin n_bad++; $display("FAIL single_busy_txd got=%b exp=11", {busy, txd}); end
        req1 = 1'b0;
        clk_step(1'b0);
        n_total++; if (gnt1 !== 1'b0)    begin n_bad++; $display("FAIL single_gnt_pulse got=%b exp=0", gnt1); end
        run_frame(16, fe, fo, bi, gl, gn);
        n_total++; if (fe !== 11'b10_1010_0101_0) begin n_bad++; $display("FAIL single_frame got=%b exp=%b", fe, 11'b10_1010_0101_0); end
        n_total++; if (bi !== 0)         begin n_bad++; $display("FAIL single_bit_idx got=%0d exp=0 bad indices", bi); end
        n_total++; if (gl !== 0)         begin n_bad++; $display("FAIL single_hold got=%0d exp=0 anomalies", gl); end
        n_total++; if ({done, busy, txd} !== 3'b101) begin n_bad++; $display("FAIL single_done got=%b exp=101", {done, busy, txd}); end
        clk_step(1'b0);
        n_total++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL single_after got=%b exp=00", {done, busy}); end
    endtask

    task automatic test_tie();
        logic [10:0] fe, fo; int bi, gl, gn;
        do_reset();
        data1 = 8'h3C; data2 = 8'h01; req1 = 1'b1; req2 = 1'b1;
        clk_step(1'b0);
        n_total++; if ({gnt1, gnt2, owner} !== 3'b100) begin n_bad++; $display("FAIL tie_first got=%b exp=100", {gnt1, gnt2, owner}); end
        run_frame(4, fe, fo, bi, gl, gn);
        n_total++; if (fe !== {1'b1, 1'b0, 8'h3C, 1'b0}) begin n_bad++; $display("FAIL tie_frame1 got=%b exp=%b", fe, {1'b1, 1'b0, 8'h3C, 1'b0}); end
        n_total++; if (gn !== 0)         begin n_bad++; $display("FAIL tie_busy_ignore got=%0d exp=0 grants", gn); end
        clk_step(1'b0);
        n_total++; if ({gnt1, gnt2, owner} !== 3'b011) begin n_bad++; $display("FAIL tie_second got=%b exp=011", {gnt1, gnt2, owner}); end
        req1 = 1'b0; req2 = 1'b0;
        run_frame(4, fe, fo, bi, gl, gn);
        n_total++; if (fe !== {1'b1, 1'b1, 8'h01, 1'b0}) begin n_bad++; $display("FAIL tie_frame2 got=%b exp=%b", fe, {1'b1, 1'b1, 8'h01, 1'b0}); end
    endtask

    task automatic test_round_robin();
        logic [10:0] fe, fo; int bi, gl, gn;
        logic [3:0]  exp_own;
        exp_own = 4'b1010;
        do_reset();
        data1 = 8'h81; data2 = 8'h7F; req1 = 1'b1; req2 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            clk_step(1'b0);
            n_total++; if (owner !== exp_own[f]) begin n_bad++; $display("FAIL rr_owner%0d got=%b exp=%b", f, owner, exp_own[f]); end
            n_total++; if ({gnt2, gnt1} !== (exp_own[f] ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", f, {gnt2, gnt1}, (exp_own[f] ? 2'b10 : 2'b01)); end
            run_frame(4, fe, fo, bi, gl, gn);
            n_total++; if (gn !== 0) begin n_bad++; $display("FAIL rr_extra_gnt%0d got=%0d exp=0", f, gn); end
            n_total++; if (fe !== (exp_own[f] ? {1'b1, 1'b1, 8'h7F, 1'b0} : {1'b1, 1'b0, 8'h81, 1'b0})) begin n_bad++; $display("FAIL rr_frame%0d got=%b", f, fe); end
        end
        req1 = 1'b0; req2 = 1'b0;
        clk_step(1'b0);
    endtask

    task automatic test_en_at_grant();
        logic [10:0] fe, fo; int bi, gl, gn;
        do_reset();
        data1 = 8'h5A; req1 = 1'b1;
        clk_step(1'b1);
        n_total++; if ({gnt1, busy, txd} !== 3'b111) begin n_bad++; $display("FAIL engrant_gnt got=%b exp=111", {gnt1, busy, txd}); end
        req1 = 1'b0;
        run_frame(16, fe, fo, bi, gl, gn);
        n_total++; if (gl !== 0) begin n_bad++; $display("FAIL engrant_early_start got=%0d exp=0 anomalies", gl); end
        n_total++; if (fe !== {1'b1, 1'b0, 8'h5A, 1'b0}) begin n_bad++; $display("FAIL engrant_frame got=%b exp=%b", fe, {1'b1, 1'b0, 8'h5A, 1'b0}); end
        n_total++; if (bi !== 0) begin n_bad++; $display("FAIL engrant_bit_idx got=%0d exp=0 bad indices", bi); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] fe, fo; int bi, gl, gn;
        do_reset();
        data2 = 8'hC3; req2 = 1'b1;
        clk_step(1'b0);
        n_total++; if ({gnt2, owner} !== 2'b11) begin n_bad++; $display("FAIL mid_gnt got=%b exp=11", {gnt2, owner}); end
        req2 = 1'b0;
        for (int b = 0; b <= 5; b++) begin
            repeat (3) clk_step(1'b0);
            clk_step(1'b1);
        end
        n_total++; if ({bit_idx, txd} !== {4'd5, 1'b0}) begin n_bad++; $display("FAIL mid_pos got=%b exp=%b", {bit_idx, txd}, {4'd5, 1'b0}); end
        rst = 1'b1;
        clk_step(1'b0);
        rst = 1'b0;
        n_total++; if ({txd, busy, bit_idx, done, owner} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL mid_reset got=%b exp=%b", {txd, busy, bit_idx, done, owner}, {1'b1, 1'b0, 4'd0, 1'b0, 1'b1}); end
        repeat (4) clk_step(1'b1);
        n_total++; if ({done, busy, txd} !== 3'b001) begin n_bad++; $display("FAIL mid_no_done got=%b exp=001", {done, busy, txd}); end
        data2 = 8'h96; req2 = 1'b1;
        clk_step(1'b0);
        n_total++; if (gnt2 !== 1'b1) begin n_bad++; $display("FAIL mid_regrant got=%b exp=1", gnt2); end
        req2 = 1'b0;
        run_frame(4, fe, fo, bi, gl, gn);
        n_total++; if (fe !== {1'b1, 1'b0, 8'h96, 1'b0}) begin n_bad++; $display("FAIL mid_frame got=%b exp=%b", fe, {1'b1, 1'b0, 8'h96, 1'b0}); end
        n_total++; if (done !== 1'b1) begin n_bad++; $display("FAIL mid_done got=%b exp=1", done); end
    endtask

    task automatic test_odd_parity();
        logic [10:0] fe, fo; int bi, gl, gn;
        do_reset();
        data1 = 8'hFF; req1 = 1'b1;
        clk_step(1'b0);
        n_total++; if ({gnt1, odd_gnt1} !== 2'b11) begin n_bad++; $display("FAIL odd_gnt got=%b exp=11", {gnt1, odd_gnt1}); end
        // New request and changed data while the frame is in flight.
        req1 = 1'b0; req2 = 1'b1; data1 = 8'h00; data2 = 8'h00;
        run_frame(4, fe, fo, bi, gl, gn);
        n_total++; if (fo !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin n_bad++; $display("FAIL odd_frame got=%b exp=%b", fo, {1'b1, 1'b1, 8'hFF, 1'b0}); end
        n_total++; if (fe !== {1'b1, 1'b0, 8'hFF, 1'b0}) begin n_bad++; $display("FAIL even_ff_frame got=%b exp=%b", fe, {1'b1, 1'b0, 8'hFF, 1'b0}); end
        n_total++; if (gn !== 0) begin n_bad++; $display("FAIL odd_busy_ignore got=%0d exp=0 grants", gn); end
        clk_step(1'b0);
        n_total++; if ({gnt2, owner} !== 2'b11) begin n_bad++; $display("FAIL odd_late_gnt got=%b exp=11", {gnt2, owner}); end
        req2 = 1'b0;
        clk_step(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_send();
        test_tie();
        test_round_robin();
        test_en_at_grant();
        test_reset_mid();
        test_odd_parity();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
# tx_arbiter

Two-source transmit controller for the serial output path. It arbitrates between two byte requesters using round-robin arbitration, latches the winning byte, and builds an 11-bit frame (start bit, 8 data bits LSB-first, parity, stop bit). It then sequences the frame onto `txd`, one bit per baud-enable tick from the existing baud generator. It replaces the OR-of-buttons start and the free bit counter in front of the output multiplexer.

## Interface
- `PARITY_ODD`, default 0: 0 = even parity (total ones in data+parity even); 1 = odd parity.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  baud tick, one `clk` wide, from the baud generator.
- `req1`, `req2`  in  1 each  level requests from source 1 / source 2.
- `data1`, `data2`  in  8 each  byte offered by each source; sampled only at grant.
- `gnt1`, `gnt2`  out  1 each  one-cycle pulse: that source's byte was latched.
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  high from the grant until the frame completes.
- `done`  out  1  one-cycle pulse after the stop bit period ends.
- `owner`  out  1  0 = source 1, 1 = source 2; owner of the current or last frame.
- `bit_idx`  out  4  index of the bit currently on `txd` (0..10); debug.

## Operation
- All outputs are registered.
- Reset values:
  - `state` = IDLE, `txd` = 1.
  - `busy`, `gnt1`, `gnt2`, `done` = 0.
  - `bit_idx` = 0, `owner` = 1.
  - Because `owner` resets to 1 (source 2 last), source 1 wins the first tie.
- Frame layout:
  - f[0] = 0 (start bit).
  - f[8:1] = data[7:0], so f[1] = data[0].
  - f[9] = ^data XOR `PARITY_ODD`.
  - f[10] = 1 (stop bit).
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - `txd` = 1, `busy` = 0.
  - If either request is high at a `clk` edge: grant the source, latch its byte into the frame register, set `owner`, pulse its `gnt`, set `busy` = 1, go to WAIT.
  - Only one request high: that source wins.
  - Both high: the source that is not `owner` wins.
- WAIT:
  - Holds `txd` = 1 until the next `en`.
  - On `en`: go to SEND, `bit_idx` = 0, `txd` = 0 (start bit).
- SEND, on each `en`:
  - If `bit_idx` = 10: go to IDLE, `txd` = 1, `busy` = 0, pulse `done`.
  - Otherwise: `bit_idx` increments and `txd` = f[`bit_idx`+1].
  - Cycles without `en` hold all state.
- Requests are level-sensitive and never queued.
  - A request present while `busy` is ignored.
  - A request is re-evaluated in each IDLE cycle.
  - A requester must drop `req` on seeing its `gnt`. A `req` still high in the IDLE cycle after `done` sends the byte again, which is intended behaviour.
- `data1`/`data2` changes after grant do not affect the frame in flight.

## Timing
- Grant latency: a request seen at IDLE edge t gives `gnt` high in cycle t+1 (the first WAIT cycle).
- An `en` coinciding with the grant edge is not used. The start bit begins at the first `en` strictly after the grant.
- Each frame bit lasts exactly one `en` period. `txd` changes only on `en` edges while in SEND.
- A frame occupies 11 `en` periods from start-bit edge to stop-bit end.
- `done` is high during the first IDLE cycle. A grant may be issued at that same edge, so `gnt` follows `done` by one cycle.
- Back-to-back frames therefore have at least one idle-high stop period plus the WAIT interval between them.
- Reset mid-frame: the next cycle shows IDLE with `txd` = 1 and no `done` pulse. The aborted frame is lost, and `owner` returns to 1.
- Simultaneous `rst` and request: reset wins and no grant is issued.

## Test plan
- Single send: `req1` with `data1` = 0xA5, `PARITY_ODD` = 0, `en` every 16 clocks.
  - Expect `gnt1` for one cycle, `owner` = 0.
  - Expect `txd` sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 16 clocks long.
  - Expect `done` one cycle after the stop period, and `busy` = 0 afterwards.
- Tie: `req1` and `req2` rise together after reset with `data2` = 0x01.
  - Expect source 1 to be served first.
  - With both still held, the next grant goes to `gnt2` and its frame carries parity bit 1.
- Round-robin: keep both requests high for four frames.
  - Expect `owner` sequence 0,1,0,1.
  - Expect exactly one `gnt` pulse per frame.
- `en` coinciding with the grant edge: that tick is ignored. The start bit begins exactly one `en` period later.
- Reset at `bit_idx` = 5: the next cycle shows `txd` = 1, `busy` = 0, `bit_idx` = 0, and no `done` pulse.
  - A fresh `req2` afterwards sends a complete frame.
- Odd parity: `PARITY_ODD` = 1 with `data1` = 0xFF gives f[9] = 1.
  - A request raised while `busy` is ignored until IDLE, and `data` changes mid-frame do not alter `txd`.
